eight_way_request_arbiter: RTL and testbench



---
 rtl/arb_defs_pkg.sv | 11 +
 rtl/arb_lowest_set_pick.sv | 20 ++
 rtl/eight_way_request_arbiter.sv | 119 +++++++++++
 tb/tb_eight_way_request_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arb_defs_pkg.sv
// Shared constants and FSM state encoding for the eight-way arbiter.
// Optional round-robin mode is selected by ARB_ROUND_ROBIN_EN.
package arb_defs;
  localparam int ARB_N = 8;
  localparam int ARB_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/arb_lowest_set_pick.sv
// Combinational lowest-set-bit picker over an ARB_N-bit vector.
// Index is zero and o_found low when the vector is empty.
module arb_lowest_set_pick
  import arb_defs::*;
(
  input  logic [ARB_N-1:0] i_vec,
  output logic [ARB_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = |i_vec;
    // Descending scan so the lowest set bit is written last.
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = ARB_W'(i);
    end
  end

endmodule

// File: rtl/eight_way_request_arbiter.sv
// Eight-requester arbiter with registered one-hot grant and hold limit.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed.
module eight_way_request_arbiter
  import arb_defs::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic [ARB_W-1:0] gnt_pos,
  output logic             gnt_valid,
  output logic             preempt
);

  arb_state_t       r_state, w_nx_state;
  logic [7:0]       r_hold, w_nx_hold;
  logic [ARB_W-1:0] r_owner, w_nx_owner;
  logic [ARB_N-1:0] r_gnt, w_nx_gnt;
  logic             r_valid, w_nx_valid;
  logic             r_pre, w_nx_pre;

  logic [ARB_N-1:0] w_rot;
  logic [ARB_W-1:0] w_pick;
  logic [ARB_W-1:0] w_win;
  logic             w_found;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ARB_W-1:0] r_ptr;
  logic [ARB_W-1:0] w_nx_ptr;

  // Rotate right by ptr; index arithmetic wraps naturally in 3 bits.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < ARB_N; i++) begin
      w_rot[i] = req[ARB_W'(i) + r_ptr];
    end
  end

  assign w_win = w_pick + r_ptr;

  assign w_nx_ptr = (r_state == ST_IDLE && w_found)
                  ? w_win + ARB_W'(1)
                  : r_ptr;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_ptr <= '0;
    else          r_ptr <= w_nx_ptr;
  end
`else
  assign w_rot = req;
  assign w_win = w_pick;
`endif

  arb_lowest_set_pick u_pick (
    .i_vec   (w_rot),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_pre   <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_hold  <= w_nx_hold;
      r_owner <= w_nx_owner;
      r_gnt   <= w_nx_gnt;
      r_valid <= w_nx_valid;
      r_pre   <= w_nx_pre;
    end
  end

  always_comb begin
    w_nx_state = r_state;
    w_nx_hold  = r_hold;
    w_nx_owner = r_owner;
    w_nx_gnt   = r_gnt;
    w_nx_valid = r_valid;
    w_nx_pre   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nx_state = ST_OWNED;
          w_nx_hold  = '0;
          w_nx_owner = w_win;
          w_nx_gnt   = ARB_N'(1) << w_win;
          w_nx_valid = 1'b1;
        end
      end
      ST_OWNED: begin
        // Release always drops to IDLE, leaving a one-cycle bubble.
        if (!req[r_owner] || r_hold == 8'(MAX_HOLD - 1)) begin
          w_nx_state = ST_IDLE;
          w_nx_hold  = '0;
          w_nx_owner = '0;
          w_nx_gnt   = '0;
          w_nx_valid = 1'b0;
          w_nx_pre   = req[r_owner];
        end else begin
          w_nx_hold  = r_hold + 8'd1;
        end
      end
      default: w_nx_state = ST_IDLE;
    endcase
  end

  assign gnt       = r_gnt;
  assign gnt_pos   = r_owner;
  assign gnt_valid = r_valid;
  assign preempt   = r_pre;

endmodule

// File: tb/tb_eight_way_request_arbiter.sv
// Directed bench for eight_way_request_arbiter, table-driven.
// Covers fixed priority by default and ARB_ROUND_ROBIN_EN when defined.
module tb_eight_way_request_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int MH = 2;
`else
  localparam int MH = 4;
`endif

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] req = 8'hFF;
  logic [7:0] gnt;
  logic [2:0] gnt_pos;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;

  eight_way_request_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .req       (req),
    .gnt       (gnt),
    .gnt_pos   (gnt_pos),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rq;
    logic [7:0] g;
    logic [2:0] p;
    logic       pre;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] eg,
                         input logic [2:0] ep, input logic epre);
    chk({nm, ".gnt"}, gnt, eg);
    chk({nm, ".gnt_pos"}, {5'd0, gnt_pos}, {5'd0, ep});
    chk({nm, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, (eg != 8'h00)});
    chk({nm, ".preempt"}, {7'd0, preempt}, {7'd0, epre});
  endtask

  task automatic step(input logic [7:0] v);
    req = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{8'h10, 8'h10, 3'd4, 1'b0};
    tbl[1]  = '{8'h10, 8'h10, 3'd4, 1'b0};
    tbl[2]  = '{8'h10, 8'h10, 3'd4, 1'b0};
    tbl[3]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[4]  = '{8'hA4, 8'h04, 3'd2, 1'b0};
    tbl[5]  = '{8'hA0, 8'h00, 3'd0, 1'b0};
    tbl[6]  = '{8'hA0, 8'h20, 3'd5, 1'b0};
    tbl[7]  = '{8'hA1, 8'h20, 3'd5, 1'b0};
    tbl[8]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[9]  = '{8'h01, 8'h01, 3'd0, 1'b0};
    tbl[10] = '{8'h01, 8'h01, 3'd0, 1'b0};
    tbl[11] = '{8'h01, 8'h01, 3'd0, 1'b0};
    tbl[12] = '{8'h01, 8'h01, 3'd0, 1'b0};
    tbl[13] = '{8'h01, 8'h00, 3'd0, 1'b1};
    tbl[14] = '{8'h01, 8'h01, 3'd0, 1'b0};
    tbl[15] = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[16] = '{8'h00, 8'h00, 3'd0, 1'b0};

    // Held in reset with all requests asserted.
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 3'd0, 1'b0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    chk_all("first_grant", 8'h01, 3'd0, 1'b0);

`ifdef ARB_ROUND_ROBIN_EN
    // Owner j/3 holds for two cycles, then a preempted bubble.
    for (int j = 1; j < 27; j++) begin
      int k;
      int ph;
      k  = (j / 3) % 8;
      ph = j % 3;
      step(8'hFF);
      if (ph < 2) chk_all($sformatf("rr%0d", j), 8'(1) << k, 3'(k), 1'b0);
      else        chk_all($sformatf("rr%0d", j), 8'h00, 3'd0, 1'b1);
    end
    step(8'h00);
    chk_all("rr_idle", 8'h00, 3'd0, 1'b0);
`else
    step(8'h00);
    chk_all("drop0", 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rq);
      chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].p, tbl[i].pre);
    end
`endif

    step(8'h80);
    chk_all("own7", 8'h80, 3'd7, 1'b0);
    step(8'h00);
    chk_all("rel7", 8'h00, 3'd0, 1'b0);
    step(8'h81);
    chk_all("wrap0", 8'h01, 3'd0, 1'b0);

    // Asynchronous reset mid-cycle while granted.
    #3;
    aresetn = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    step(8'h81);
    chk_all("post_rst", 8'h01, 3'd0, 1'b0);
    step(8'h00);
    chk_all("post_rst_rel", 8'h00, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
